display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Downstream display stage of the clock core.
- Takes four BCD time digits (HH:MM) and the settings-mode code from the mode controller.
- Time-multiplexes them onto one shared 7-segment bus with one-hot digit enables, driving the board pins o_Segments/o_Digits.
- Blinks the field under edit so the user sees which field the Up button changes.

Parameters:
- SCAN_DIV, 32: clock cycles each digit stays enabled; must be ≥ 2.
- BLINK_DIV, 16384: clock cycles per blink half-period (0.5 s at 32768 Hz); must be ≥ 2.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  reset; synchronous, active-high
- i_Hour_Tens  in  4  BCD hour tens
- i_Hour_Units  in  4  BCD hour units
- i_Min_Tens  in  4  BCD minute tens
- i_Min_Units  in  4  BCD minute units
- i_Mode  in  2  mode code: 00 normal, 01 settings entry, 10 set minutes, 11 set hours
- i_Edit_Pulse  in  1  one-cycle pulse on each accepted Up press
- o_Segments  out  8  bit7 = dot, bits6:0 = gfedcba; active-high
- o_Digits  out  4  one-hot digit enable, active-high; bit3 = hour tens … bit0 = minute units

Behaviour:
- Reset (i_Reset=1 at a clock edge): all internal state and outputs cleared.
  - scan_cnt=0, idx=0, blink_cnt=0, blink_on=1.
  - o_Segments=8'h00, o_Digits=4'b0000.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal it wraps to 0 and idx advances 0→1→2→3→0.
  - Digit order: idx0 = hour tens, idx1 = hour units, idx2 = minute tens, idx3 = minute units.
- Outputs are registered. Every non-reset edge:
  - o_Digits <= onehot(idx): 1000 / 0100 / 0010 / 0001.
  - o_Segments <= encode(selected digit).
  - Outputs lag idx and the inputs by 1 cycle.
  - The first non-reset edge gives o_Digits=4'b1000.
  - o_Digits is never 0000 outside reset.
- Encoding: 0..9 map to 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (bits6:0). Non-BCD values (A..F) give bits6:0 = 0.
- Dot: bit7=1 exactly when idx==1 (hour units), in every mode, and also during blanking.
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1.
  - blink_on toggles at terminal.
  - The counter runs in all modes.
- Blink restart: i_Edit_Pulse=1, or i_Mode different from its previous-cycle value, forces blink_cnt=0 and blink_on=1 on that edge. This restart has priority over the terminal toggle.
- Blank set (which digits blink):
  - Mode 00: none.
  - Mode 01: all four digits.
  - Mode 10: idx 2 and 3.
  - Mode 11: idx 0 and 1.
- Blanking: when blink_on=0 and idx is in the blank set, bits6:0 = 0. o_Digits stays asserted.
- Mode change mid-scan: takes effect on the next edge. The scan position is not disturbed.
- Input changes mid-digit: take effect on the next edge. There is no per-digit latching.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in mode 00 only, when i_Hour_Tens==0 the idx0 digit outputs bits6:0 = 0. o_Digits still scans normally. In modes 01/10/11 a zero hour tens is displayed so the field stays visible while being set.
- Undefined: hour tens 0 is displayed as 3F.

Decomposition:
- Shared package clock_pkg holds:
  - mode encodings MODE_NORMAL, MODE_SET_ENTRY, MODE_SET_MIN, MODE_SET_HOUR;
  - digit index constants IDX_HOUR_TENS..IDX_MIN_UNITS;
  - the 10-entry segment pattern table, shared with the existing testbench patterns.
- One sub-module: seg7_encoder, combinational 4-bit BCD → 7-bit pattern with the invalid code mapped to 0.
- Counter widths are derived with $clog2 of the parameters.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, time 12:34):
- Reset for 3 cycles, then release:
  - o_Digits=0000 and o_Segments=00 during reset.
  - First edge after release gives o_Digits=1000, o_Segments=8'h06.
  - Then 0100/8'hDB, 0010/8'h4F, 0001/8'h66, each held 4 cycles; the sequence then repeats.
- Mode 10 held for 32 cycles:
  - idx2/3 segments alternate between digit values and 00 every 8 cycles.
  - idx0/1 never blank; idx1 shows 8'hDB in both blink phases.
- Mode 11, pulse i_Edit_Pulse while blink_on=0:
  - Next cycle blink_on=1 and the hour digits visible.
  - Next blank begins exactly 8 cycles after the pulse.
- Mode 01: all four digits blank together during the off phase. Hour units shows 8'h80 (dot only). o_Digits remains one-hot.
- i_Min_Units=4'hC → idx3 shows 8'h00. With LEADING_ZERO_BLANK_EN defined, time 05:00 in mode 00 → idx0 shows 8'h00; in mode 11 it shows 8'h3F.
- Assert i_Reset mid-scan at idx=2 → after release the scan restarts at 1000 with blink_on=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock core display path.
//   - mode_e       : settings-mode codes driven by the mode controller
//   - IDX_*        : scan position of each display digit
//   - SEG_TABLE    : gfedcba patterns for BCD 0..9 (active-high segments)
//   - digit_onehot : scan index -> one-hot digit enable (bit3 = hour tens)
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'b00,
    MODE_SET_ENTRY = 2'b01,
    MODE_SET_MIN   = 2'b10,
    MODE_SET_HOUR  = 2'b11
  } mode_e;

  localparam logic [1:0] IDX_HOUR_TENS  = 2'd0;
  localparam logic [1:0] IDX_HOUR_UNITS = 2'd1;
  localparam logic [1:0] IDX_MIN_TENS   = 2'd2;
  localparam logic [1:0] IDX_MIN_UNITS  = 2'd3;

  // Entry N holds the pattern for BCD digit N.
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bus between the clock core and the display scan multiplexer.
//   i_Hour_Tens/i_Hour_Units/i_Min_Tens/i_Min_Units : BCD time digits (HH:MM)
//   i_Mode        : settings-mode code (see clock_pkg::mode_e)
//   i_Edit_Pulse  : one-cycle pulse per accepted Up press
//   o_Segments    : bit7 = dot, bits6:0 = gfedcba, active-high
//   o_Digits      : one-hot digit enable, bit3 = hour tens .. bit0 = minute units
// master : the clock core side (drives time/mode, observes pins)
// slave  : the scan multiplexer
interface display_scan_mux_if;
  logic [3:0] i_Hour_Tens;
  logic [3:0] i_Hour_Units;
  logic [3:0] i_Min_Tens;
  logic [3:0] i_Min_Units;
  logic [1:0] i_Mode;
  logic       i_Edit_Pulse;
  logic [7:0] o_Segments;
  logic [3:0] o_Digits;

  modport master (
    output i_Hour_Tens, i_Hour_Units, i_Min_Tens, i_Min_Units, i_Mode, i_Edit_Pulse,
    input  o_Segments, o_Digits
  );

  modport slave (
    input  i_Hour_Tens, i_Hour_Units, i_Min_Tens, i_Min_Units, i_Mode, i_Edit_Pulse,
    output o_Segments, o_Digits
  );
endinterface

// File: rtl/seg7_encoder.sv
// Combinational BCD to 7-segment encoder.
//   i_Bcd     : 4-bit digit value
//   o_Pattern : gfedcba pattern, active-high; codes A..F give all segments off
module seg7_encoder
  import clock_pkg::*;
(
  input  logic [3:0] i_Bcd,
  output logic [6:0] o_Pattern
);

  always_comb begin
    o_Pattern = 7'd0;
    if (i_Bcd <= 4'd9) o_Pattern = SEG_TABLE[i_Bcd];
  end

endmodule

// File: rtl/display_scan_mux.sv
// Display scan multiplexer: time-multiplexes the four HH:MM digits onto one
// shared 7-segment bus and blinks the field currently being edited.
//   i_Clock : system clock
//   i_Reset : synchronous, active-high reset
//   bus     : display_scan_mux_if.slave (time digits, mode, edit pulse in;
//             o_Segments / o_Digits out, both registered)
// Parameters:
//   SCAN_DIV  : cycles each digit stays enabled (>= 2)
//   BLINK_DIV : cycles per blink half-period (>= 2)
// Optional build macro LEADING_ZERO_BLANK_EN: in normal mode a zero hour-tens
// digit is shown dark (digit enable still scans).
module display_scan_mux
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 32,
  parameter int BLINK_DIV = 16384
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  display_scan_mux_if.slave bus
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [1:0]         idx_q,       idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q,  blink_on_d;
  logic [1:0]         mode_prev_q, mode_prev_d;
  logic [7:0]         seg_q,       seg_d;
  logic [3:0]         dig_q,       dig_d;

  logic [3:0] digit_sel;
  logic [6:0] pattern;
  logic       in_blank_set;
  logic       lz_blank;
  logic       blink_restart;

  seg7_encoder u_enc (
    .i_Bcd     (digit_sel),
    .o_Pattern (pattern)
  );

  always_comb begin
    // Scan position
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    // Any edit or mode change restarts the blink in the visible phase so the
    // user immediately sees the field they just touched.
    blink_restart = bus.i_Edit_Pulse || (bus.i_Mode != mode_prev_q);
    blink_cnt_d   = blink_cnt_q + 1'b1;
    blink_on_d    = blink_on_q;
    if (blink_restart) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
    mode_prev_d = bus.i_Mode;

    // Digit selection
    case (idx_q)
      IDX_HOUR_TENS:  digit_sel = bus.i_Hour_Tens;
      IDX_HOUR_UNITS: digit_sel = bus.i_Hour_Units;
      IDX_MIN_TENS:   digit_sel = bus.i_Min_Tens;
      default:        digit_sel = bus.i_Min_Units;
    endcase

    case (bus.i_Mode)
      MODE_NORMAL:    in_blank_set = 1'b0;
      MODE_SET_ENTRY: in_blank_set = 1'b1;
      MODE_SET_MIN:   in_blank_set = (idx_q == IDX_MIN_TENS) || (idx_q == IDX_MIN_UNITS);
      default:        in_blank_set = (idx_q == IDX_HOUR_TENS) || (idx_q == IDX_HOUR_UNITS);
    endcase

`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (bus.i_Mode == MODE_NORMAL) && (idx_q == IDX_HOUR_TENS) &&
               (bus.i_Hour_Tens == 4'd0);
`else
    lz_blank = 1'b0;
`endif

    // The dot separates HH from MM and stays lit even while blanked.
    seg_d = {idx_q == IDX_HOUR_UNITS,
             ((!blink_on_q && in_blank_set) || lz_blank) ? 7'd0 : pattern};
    dig_d = digit_onehot(idx_q);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      mode_prev_q <= 2'd0;
      seg_q       <= 8'h00;
      dig_q       <= 4'b0000;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      mode_prev_q <= mode_prev_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  assign bus.o_Segments = seg_q;
  assign bus.o_Digits   = dig_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux (SCAN_DIV=4, BLINK_DIV=8).
// A behavioural model predicts each registered output when the inputs for an
// edge are applied; the prediction is queued and compared after the edge.
module tb_display_scan_mux;

  localparam int SD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_scan_mux_if bus ();

  display_scan_mux #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [6:0] pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state
  int         m_scan, m_idx, m_bcnt;
  logic       m_bon;
  logic [1:0] m_mprev;

  function automatic exp_t model_out();
    exp_t       e;
    logic [3:0] d;
    logic [6:0] p;
    logic       blank;
    case (m_idx)
      0:       d = bus.i_Hour_Tens;
      1:       d = bus.i_Hour_Units;
      2:       d = bus.i_Min_Tens;
      default: d = bus.i_Min_Units;
    endcase
    p = (d < 4'd10) ? pat_tbl[d] : 7'h00;
    case (bus.i_Mode)
      2'b00:   blank = 1'b0;
      2'b01:   blank = 1'b1;
      2'b10:   blank = (m_idx >= 2);
      default: blank = (m_idx <= 1);
    endcase
    if (!m_bon && blank) p = 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
    if (bus.i_Mode == 2'b00 && m_idx == 0 && bus.i_Hour_Tens == 4'd0) p = 7'h00;
`endif
    e.seg = {(m_idx == 1), p};
    e.dig = 4'b1000 >> m_idx;
    return e;
  endfunction

  // Predict the next edge from the inputs now applied, then cross that edge.
  task automatic tick();
    exp_t e;
    if (rst) begin
      e       = '0;
      m_scan  = 0;
      m_idx   = 0;
      m_bcnt  = 0;
      m_bon   = 1'b1;
      m_mprev = 2'b00;
    end else begin
      e = model_out();
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_scan++;
      end
      if (bus.i_Edit_Pulse || bus.i_Mode != m_mprev) begin
        m_bcnt = 0;
        m_bon  = 1'b1;
      end else if (m_bcnt == BD - 1) begin
        m_bcnt = 0;
        m_bon  = ~m_bon;
      end else begin
        m_bcnt++;
      end
      m_mprev = bus.i_Mode;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] ht, hu, mt, mu);
    bus.i_Hour_Tens  = ht;
    bus.i_Hour_Units = hu;
    bus.i_Min_Tens   = mt;
    bus.i_Min_Units  = mu;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== 8'h00 || bus.o_Digits !== 4'b0000 ||
          bus.o_Segments !== e.seg || bus.o_Digits !== e.dig) begin
        n_fail++;
        $display("FAIL reset: seg=%h dig=%b, required seg=00 dig=0000", bus.o_Segments, bus.o_Digits);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    exp_t e;
    logic [7:0] fix_seg [4] = '{8'h06, 8'hDB, 8'h4F, 8'h66};
    logic [3:0] fix_dig [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          bus.o_Segments !== fix_seg[(i / SD) % 4] || bus.o_Digits !== fix_dig[(i / SD) % 4]) begin
        n_fail++;
        $display("FAIL scan[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, fix_seg[(i / SD) % 4], fix_dig[(i / SD) % 4]);
      end
    end
  endtask

  task automatic test_blink_minutes();
    exp_t e;
    bus.i_Mode = 2'b10;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (bus.o_Digits == 4'b0100 && bus.o_Segments !== 8'hDB)) begin
        n_fail++;
        $display("FAIL blink_min[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
  endtask

  task automatic test_edit_pulse();
    exp_t e;
    int   guard;
    bus.i_Mode = 2'b11;
    guard = 0;
    while (m_bon && guard < 40) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig) begin
        n_fail++;
        $display("FAIL edit_wait: seg=%h dig=%b, required seg=%h dig=%b",
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
      guard++;
    end
    n_checks++;
    if (m_bon) begin
      n_fail++;
      $display("FAIL edit_wait_timeout: blink off phase not reached in %0d cycles, required < 40", guard);
    end
    bus.i_Edit_Pulse = 1'b1;
    tick();
    bus.i_Edit_Pulse = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig) begin
      n_fail++;
      $display("FAIL edit_pulse_edge: seg=%h dig=%b, required seg=%h dig=%b",
               bus.o_Segments, bus.o_Digits, e.seg, e.dig);
    end
    // Eight visible edges follow the pulse, then the hour field goes dark.
    for (int i = 1; i <= 16; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (i <= 8  && bus.o_Digits[3:2] != 2'b00 && bus.o_Segments[6:0] === 7'h00) ||
          (i >= 9  && bus.o_Digits[3:2] != 2'b00 && bus.o_Segments[6:0] !== 7'h00)) begin
        n_fail++;
        $display("FAIL edit_after[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
  endtask

  task automatic test_entry_blank();
    exp_t e;
    int   guard;
    int   dot_only;
    bus.i_Mode = 2'b00;
    guard = 0;
    while (!(m_idx == 2 && m_scan == 0) && guard < 20) begin
      tick();
      void'(sb.pop_front());
      guard++;
    end
    bus.i_Mode = 2'b01;
    dot_only = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = sb.pop_front();
      if (bus.o_Digits == 4'b0100 && bus.o_Segments == 8'h80) dot_only++;
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig || !$onehot(bus.o_Digits)) begin
        n_fail++;
        $display("FAIL entry[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
    n_checks++;
    if (dot_only == 0) begin
      n_fail++;
      $display("FAIL entry_dot_only: cycles showing 80 on hour units=%0d, required > 0", dot_only);
    end
  endtask

  task automatic test_invalid_bcd();
    exp_t e;
    bus.i_Mode = 2'b00;
    set_time(4'd1, 4'd2, 4'd3, 4'hC);
    for (int i = 0; i < 20; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (bus.o_Digits == 4'b0001 && bus.o_Segments !== 8'h00)) begin
        n_fail++;
        $display("FAIL invalid_bcd[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
  endtask

  task automatic test_hour_tens_zero();
    exp_t e;
    logic [7:0] want_normal;
`ifdef LEADING_ZERO_BLANK_EN
    want_normal = 8'h00;
`else
    want_normal = 8'h3F;
`endif
    bus.i_Mode = 2'b00;
    set_time(4'd0, 4'd5, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (bus.o_Digits == 4'b1000 && bus.o_Segments !== want_normal)) begin
        n_fail++;
        $display("FAIL zero_tens_normal[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
    // Pulsing edit every edge keeps the field in its visible phase.
    bus.i_Mode       = 2'b11;
    bus.i_Edit_Pulse = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (bus.o_Digits == 4'b1000 && bus.o_Segments !== 8'h3F)) begin
        n_fail++;
        $display("FAIL zero_tens_set_hour[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
    bus.i_Edit_Pulse = 1'b0;
  endtask

  task automatic test_mid_scan_reset();
    exp_t e;
    int   guard;
    bus.i_Mode = 2'b00;
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    guard = 0;
    while (m_idx != 2 && guard < 20) begin
      tick();
      void'(sb.pop_front());
      guard++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== 8'h00 || bus.o_Digits !== 4'b0000 ||
          bus.o_Segments !== e.seg || bus.o_Digits !== e.dig) begin
        n_fail++;
        $display("FAIL mid_reset_hold: seg=%h dig=%b, required seg=00 dig=0000", bus.o_Segments, bus.o_Digits);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = sb.pop_front();
      n_checks++;
      if (bus.o_Segments !== e.seg || bus.o_Digits !== e.dig ||
          (i == 0 && (bus.o_Digits !== 4'b1000 || bus.o_Segments !== 8'h06))) begin
        n_fail++;
        $display("FAIL mid_reset_restart[%0d]: seg=%h dig=%b, required seg=%h dig=%b", i,
                 bus.o_Segments, bus.o_Digits, e.seg, e.dig);
      end
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_Mode       = 2'b00;
    bus.i_Edit_Pulse = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    m_scan  = 0;
    m_idx   = 0;
    m_bcnt  = 0;
    m_bon   = 1'b1;
    m_mprev = 2'b00;

    test_reset();
    test_scan();
    test_blink_minutes();
    test_edit_pulse();
    test_entry_blank();
    test_invalid_bcd();
    test_hour_tens_zero();
    test_mid_scan_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule
